vscale_htif_tohost_monitor: RTL and testbench
=============================================

// Module: vscale_htif_tohost_monitor
// PURPOSE
//   Synthesizable multi-core HTIF tohost monitor for the multi-core vscale sim/FPGA top.
//   Round-robin polls CSR_ADDR_TO_HOST of NUM_CORES cores over the HTIF PCR req/resp channel.
//   Decodes pass/fail per core, enforces a cycle budget and reports sticky status.
//   Replaces ad-hoc testbench polling; usable both in Verilator and on hardware.
// PARAMETERS
//   NUM_CORES    2       cores polled; >=1; CORE_W = max(1,$clog2(NUM_CORES))
//   PCR_WIDTH    64      HTIF PCR data width (`HTIF_PCR_WIDTH)
//   ADDR_WIDTH   12      PCR address width
//   TOHOST_ADDR  12'h780 address driven on req_addr (`CSR_ADDR_TO_HOST)
//   CYCLE_WIDTH  64      cycle counter / budget width
//   STOP_ON_FAIL 1       1: first failing core ends the run; 0: keep polling remaining cores
// PORTS
//   clk          in   1            clock
//   reset        in   1            synchronous, active-low
//   enable       in   1            start/continue polling; 0 freezes FSM and counter
//   max_cycles   in   CYCLE_WIDTH  cycle budget; 0 = no timeout
//   req_valid    out  1            PCR request valid
//   req_ready    in   1            PCR request accepted
//   req_rw       out  1            always 0 (read)
//   req_addr     out  ADDR_WIDTH   always TOHOST_ADDR
//   req_data     out  PCR_WIDTH    always 0
//   req_core     out  CORE_W       core targeted by current request
//   resp_valid   in   1            PCR response valid
//   resp_ready   out  1            monitor can take response
//   resp_data    in   PCR_WIDTH    tohost value
//   core_done    out  NUM_CORES    sticky: core wrote nonzero tohost
//   core_fail    out  NUM_CORES    sticky: core wrote tohost>1
//   all_done     out  1            every core_done set, or run ended by STOP_ON_FAIL
//   any_fail     out  1            |core_fail
//   timeout      out  1            sticky: budget exhausted before all_done
//   fail_core    out  CORE_W       index of first failing core
//   fail_code    out  PCR_WIDTH-1  resp_data>>1 of first failure
//   cycle_count  out  CYCLE_WIDTH  enabled cycles since reset
// BEHAVIOUR
//   Reset (reset==0 at posedge): all outputs 0, state IDLE, ptr=0; an outstanding request is abandoned.
//   States: IDLE -> REQ (enable) ; REQ -> WAIT (req_valid&req_ready) ; WAIT -> REQ/DONE on resp ; DONE terminal.
//   REQ: req_valid=1, req_core=ptr; req_valid stays high until accepted; req_core stable while valid.
//   WAIT: resp_ready=1 only here; resp_valid outside WAIT is ignored.
//   Response decode (resp_valid in WAIT):
//     0 -> no change; ptr advances.
//     1 -> core_done[ptr]=1 (pass).
//     >1 -> core_done[ptr]=1, core_fail[ptr]=1; if first failure, latch fail_core=ptr, fail_code=resp_data>>1.
//   ptr advance: next index after ptr (mod NUM_CORES) whose core_done is 0 (incl. this response's update).
//     None left -> DONE, all_done=1. NUM_CORES=1 re-polls core 0.
//   STOP_ON_FAIL=1: a failure response -> DONE with all_done=1 the next cycle.
//   cycle_count: +1 each cycle enable=1 and state!=DONE; saturates at all-ones, never wraps.
//   Timeout: when max_cycles!=0 and cycle_count==max_cycles at posedge, state!=DONE -> timeout=1, DONE.
//     Same edge as a response: the response is decoded first; if it sets all_done, timeout stays 0.
//   enable=0: FSM and counter hold; an asserted req_valid stays asserted (no retraction).
//   DONE: req_valid=0, resp_ready=0; all status held until reset.
//   Latency: one poll = 1 REQ cycle (if ready) + response wait; min 2 cycles/core.
// TESTING
//   1 NUM_CORES=2, resp 0,0 then 1 for core0, 1 for core1 -> core_done=2'b11, all_done=1, any_fail=0, timeout=0.
//   2 core1 resp 0x15 (STOP_ON_FAIL=1) -> core_fail=2'b10, fail_core=1, fail_code=10, all_done=1 next cycle, req_valid=0.
//   3 max_cycles=20, resp always 0 -> timeout=1 when cycle_count==20, cycle_count holds 20, all_done=0.
//   4 req_ready low 5 cycles -> req_valid held, req_core stable; resp_valid during REQ ignored.
//   5 reset low mid-WAIT -> next cycle all outputs 0, state IDLE; polling restarts at core 0.
//   6 STOP_ON_FAIL=0, core0 resp 7, core1 resp 1 -> fail_code=3, fail_core=0, all_done=1, any_fail=1.

Source files
------------

// File: rtl/vscale_htif_tohost_monitor.sv
// HTIF tohost monitor: round-robin polls each core's tohost CSR over the PCR
// request/response channel and keeps sticky pass/fail/timeout status for the run.
module vscale_htif_tohost_monitor #(
  parameter int                    NUM_CORES    = 2,
  parameter int                    PCR_WIDTH    = 64,
  parameter int                    ADDR_WIDTH   = 12,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR  = 12'h780,
  parameter int                    CYCLE_WIDTH  = 64,
  parameter bit                    STOP_ON_FAIL = 1'b1,
  localparam int                   CORE_W       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [CYCLE_WIDTH-1:0] max_cycles,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic                   req_rw,
  output logic [ADDR_WIDTH-1:0]  req_addr,
  output logic [PCR_WIDTH-1:0]   req_data,
  output logic [CORE_W-1:0]      req_core,
  input  logic                   resp_valid,
  output logic                   resp_ready,
  input  logic [PCR_WIDTH-1:0]   resp_data,
  output logic [NUM_CORES-1:0]   core_done,
  output logic [NUM_CORES-1:0]   core_fail,
  output logic                   all_done,
  output logic                   any_fail,
  output logic                   timeout,
  output logic [CORE_W-1:0]      fail_core,
  output logic [PCR_WIDTH-2:0]   fail_code,
  output logic [CYCLE_WIDTH-1:0] cycle_count
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                   state, state_next;
  logic [CORE_W-1:0]        ptr, ptr_next;
  logic [NUM_CORES-1:0]     done_next, fail_next;
  logic [CORE_W-1:0]        fail_core_next;
  logic [PCR_WIDTH-2:0]     fail_code_next;
  logic                     all_done_next, timeout_next;
  logic [CYCLE_WIDTH-1:0]   count_next;

  logic                     resp_nonzero, resp_is_fail;
  logic [NUM_CORES-1:0]     ptr_onehot;
  logic                     found;
  logic [CORE_W-1:0]        next_idx, idx_c;

  assign req_valid  = (state == REQ);
  assign resp_ready = (state == WAIT) && enable;
  assign req_rw     = 1'b0;
  assign req_addr   = TOHOST_ADDR;
  assign req_data   = '0;
  assign req_core   = ptr;
  assign any_fail   = |core_fail;

  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    done_next      = core_done;
    fail_next      = core_fail;
    fail_core_next = fail_core;
    fail_code_next = fail_code;
    all_done_next  = all_done;
    timeout_next   = timeout;
    count_next     = cycle_count;
    resp_nonzero   = |resp_data;
    resp_is_fail   = |resp_data[PCR_WIDTH-1:1];
    ptr_onehot     = NUM_CORES'(1) << ptr;
    found          = 1'b0;
    next_idx       = ptr;
    idx_c          = ptr;

    if (enable && state != DONE) begin
      count_next = (&cycle_count) ? cycle_count : cycle_count + CYCLE_WIDTH'(1);
      case (state)
        IDLE: state_next = REQ;
        REQ:  if (req_ready) state_next = WAIT;
        WAIT: begin
          if (resp_valid) begin
            if (resp_nonzero) done_next = core_done | ptr_onehot;
            if (resp_is_fail) begin
              fail_next = core_fail | ptr_onehot;
              if (core_fail == '0) begin
                fail_core_next = ptr;
                fail_code_next = resp_data[PCR_WIDTH-1:1];
              end
            end
            // Scan forward from ptr+1, wrapping back to ptr itself last.
            for (int i = 1; i <= NUM_CORES; i++) begin
              idx_c = CORE_W'((int'(ptr) + i) % NUM_CORES);
              if (!found && !done_next[idx_c]) begin
                found    = 1'b1;
                next_idx = idx_c;
              end
            end
            if ((STOP_ON_FAIL && resp_is_fail) || !found) begin
              state_next    = DONE;
              all_done_next = 1'b1;
            end else begin
              state_next = REQ;
              ptr_next   = next_idx;
            end
          end
        end
        default: state_next = state;
      endcase
      // A response completing the run on this edge takes priority over the budget.
      if (max_cycles != '0 && cycle_count == max_cycles && !all_done_next) begin
        timeout_next = 1'b1;
        state_next   = DONE;
        count_next   = cycle_count;
      end
    end
  end

  // Synchronous active-low reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      core_done   <= '0;
      core_fail   <= '0;
      fail_core   <= '0;
      fail_code   <= '0;
      all_done    <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      core_done   <= done_next;
      core_fail   <= fail_next;
      fail_core   <= fail_core_next;
      fail_code   <= fail_code_next;
      all_done    <= all_done_next;
      timeout     <= timeout_next;
      cycle_count <= count_next;
    end
  end

endmodule

// File: tb/tb_vscale_htif_tohost_monitor.sv
// Directed bench for vscale_htif_tohost_monitor: one STOP_ON_FAIL=1 instance
// and one STOP_ON_FAIL=0 instance sharing clock, reset, enable and budget.
module tb_vscale_htif_tohost_monitor;

  localparam int NC = 2;
  localparam int PW = 64;
  localparam int AW = 12;
  localparam int CW = 64;
  localparam int KW = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [CW-1:0] max_cycles = '0;

  logic          req_valid, req_rw, resp_ready, all_done, any_fail, timeout;
  logic          req_ready = 1'b0, resp_valid = 1'b0;
  logic [PW-1:0] resp_data = '0;
  logic [AW-1:0] req_addr;
  logic [PW-1:0] req_data;
  logic [KW-1:0] req_core, fail_core;
  logic [NC-1:0] core_done, core_fail;
  logic [PW-2:0] fail_code;
  logic [CW-1:0] cycle_count;

  logic          n_req_valid, n_req_rw, n_resp_ready, n_all_done, n_any_fail, n_timeout;
  logic          n_req_ready = 1'b0, n_resp_valid = 1'b0;
  logic [PW-1:0] n_resp_data = '0;
  logic [AW-1:0] n_req_addr;
  logic [PW-1:0] n_req_data;
  logic [KW-1:0] n_req_core, n_fail_core;
  logic [NC-1:0] n_core_done, n_core_fail;
  logic [PW-2:0] n_fail_code;
  logic [CW-1:0] n_cycle_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vscale_htif_tohost_monitor #(.NUM_CORES(NC), .PCR_WIDTH(PW), .ADDR_WIDTH(AW),
    .TOHOST_ADDR(12'h780), .CYCLE_WIDTH(CW), .STOP_ON_FAIL(1'b1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .max_cycles(max_cycles),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_data(req_data), .req_core(req_core),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .core_done(core_done), .core_fail(core_fail), .all_done(all_done),
    .any_fail(any_fail), .timeout(timeout), .fail_core(fail_core),
    .fail_code(fail_code), .cycle_count(cycle_count));

  vscale_htif_tohost_monitor #(.NUM_CORES(NC), .PCR_WIDTH(PW), .ADDR_WIDTH(AW),
    .TOHOST_ADDR(12'h780), .CYCLE_WIDTH(CW), .STOP_ON_FAIL(1'b0)) dut_nsf (
    .clk(clk), .reset(reset), .enable(enable), .max_cycles(max_cycles),
    .req_valid(n_req_valid), .req_ready(n_req_ready), .req_rw(n_req_rw),
    .req_addr(n_req_addr), .req_data(n_req_data), .req_core(n_req_core),
    .resp_valid(n_resp_valid), .resp_ready(n_resp_ready), .resp_data(n_resp_data),
    .core_done(n_core_done), .core_fail(n_core_fail), .all_done(n_all_done),
    .any_fail(n_any_fail), .timeout(n_timeout), .fail_core(n_fail_core),
    .fail_code(n_fail_code), .cycle_count(n_cycle_count));

  task automatic reset_dut();
    enable = 1'b0; max_cycles = '0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    n_req_ready = 1'b0; n_resp_valid = 1'b0; n_resp_data = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One poll: wait for the request, accept it, answer with value next cycle.
  task automatic serve(input bit which, input logic [PW-1:0] value, output logic [KW-1:0] core_seen);
    int n = 0;
    while (((which ? n_req_valid : req_valid) !== 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("[TB] FAIL serve_wait: req_valid never rose within %0d cycles (required 1)", n);
    end
    core_seen = which ? n_req_core : req_core;
    if (which) n_req_ready = 1'b1; else req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0; n_req_ready = 1'b0;
    if (which) begin n_resp_valid = 1'b1; n_resp_data = value; end
    else begin resp_valid = 1'b1; resp_data = value; end
    @(negedge clk);
    resp_valid = 1'b0; resp_data = '0; n_resp_valid = 1'b0; n_resp_data = '0;
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge clk);
    checks++;
    if ({core_done, core_fail, all_done, any_fail, timeout, req_valid, resp_ready} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_status: got %b required 0", {core_done, core_fail, all_done, any_fail, timeout, req_valid, resp_ready});
    end
    checks++;
    if ({fail_core, fail_code, cycle_count, req_core} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values: fail_core=%0d fail_code=%0h cycle_count=%0d req_core=%0d required all 0", fail_core, fail_code, cycle_count, req_core);
    end
    checks++;
    if (req_addr !== 12'h780 || req_rw !== 1'b0 || req_data !== '0) begin
      errors++;
      $display("[TB] FAIL req_constants: addr=%h rw=%b data=%h required 780/0/0", req_addr, req_rw, req_data);
    end
  endtask

  task automatic test_all_pass();
    logic [KW-1:0] c;
    logic [KW-1:0] exp_core [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [PW-1:0] vals [4] = '{64'd0, 64'd0, 64'd1, 64'd1};
    reset_dut();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve(1'b0, vals[i], c);
      checks++;
      if (c !== exp_core[i]) begin
        errors++;
        $display("[TB] FAIL pass_poll_core[%0d]: got %0d required %0d", i, c, exp_core[i]);
      end
    end
    checks++;
    if (core_done !== 2'b11 || all_done !== 1'b1 || any_fail !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pass_status: core_done=%b all_done=%b any_fail=%b timeout=%b required 11/1/0/0", core_done, all_done, any_fail, timeout);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (cycle_count !== 64'd9 || req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pass_done_hold: cycle_count=%0d req_valid=%b required 9/0", cycle_count, req_valid);
    end
  endtask

  task automatic test_stop_on_fail();
    logic [KW-1:0] c;
    reset_dut();
    enable = 1'b1;
    serve(1'b0, 64'd0, c);
    checks++;
    if (all_done !== 1'b0 || c !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sof_first_poll: all_done=%b core=%0d required 0/0", all_done, c);
    end
    serve(1'b0, 64'h15, c);
    checks++;
    if (c !== 1'b1 || core_fail !== 2'b10 || core_done !== 2'b10 || fail_core !== 1'b1 || fail_code !== 63'd10) begin
      errors++;
      $display("[TB] FAIL sof_decode: core=%0d core_fail=%b core_done=%b fail_core=%0d fail_code=%0d required 1/10/10/1/10", c, core_fail, core_done, fail_core, fail_code);
    end
    checks++;
    if (all_done !== 1'b1 || any_fail !== 1'b1 || req_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sof_end: all_done=%b any_fail=%b req_valid=%b timeout=%b required 1/1/0/0", all_done, any_fail, req_valid, timeout);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    logic [CW-1:0] last_count = '0;
    reset_dut();
    max_cycles = 64'd20;
    req_ready = 1'b1; resp_valid = 1'b1; resp_data = '0;
    enable = 1'b1;
    @(negedge clk);
    while (timeout !== 1'b1 && n < 60) begin
      last_count = cycle_count;
      @(negedge clk);
      n++;
    end
    checks++;
    if (timeout !== 1'b1 || last_count !== 64'd20) begin
      errors++;
      $display("[TB] FAIL timeout_fire: timeout=%b count_before=%0d required 1/20", timeout, last_count);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (cycle_count !== 64'd20 || all_done !== 1'b0 || req_valid !== 1'b0 || resp_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_hold: cycle_count=%0d all_done=%b req_valid=%b resp_ready=%b required 20/0/0/0", cycle_count, all_done, req_valid, resp_ready);
    end
    req_ready = 1'b0; resp_valid = 1'b0; max_cycles = '0;
  endtask

  task automatic test_backpressure();
    logic [KW-1:0] c;
    logic [CW-1:0] saved;
    reset_dut();
    enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      req_ready = 1'b0; resp_valid = 1'b1; resp_data = 64'd1;
      @(negedge clk);
      checks++;
      if (req_valid !== 1'b1 || req_core !== 1'b0 || resp_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall[%0d]: req_valid=%b req_core=%0d resp_ready=%b required 1/0/0", i, req_valid, req_core, resp_ready);
      end
    end
    resp_valid = 1'b0; resp_data = '0;
    checks++;
    if (core_done !== 2'b00) begin
      errors++;
      $display("[TB] FAIL stray_resp: core_done=%b required 00", core_done);
    end
    enable = 1'b0; req_ready = 1'b1;
    saved = cycle_count;
    repeat (3) @(negedge clk);
    checks++;
    if (req_valid !== 1'b1 || cycle_count !== saved) begin
      errors++;
      $display("[TB] FAIL enable_hold: req_valid=%b cycle_count=%0d required 1/%0d", req_valid, cycle_count, saved);
    end
    req_ready = 1'b0; enable = 1'b1;
    serve(1'b0, 64'd1, c);
    checks++;
    if (core_done !== 2'b01 || req_core !== 1'b1 || c !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_resume: core_done=%b req_core=%0d served=%0d required 01/1/0", core_done, req_core, c);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [KW-1:0] c;
    reset_dut();
    enable = 1'b1;
    serve(1'b0, 64'd1, c);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    checks++;
    if (resp_ready !== 1'b1 || req_core !== 1'b1 || core_done !== 2'b01) begin
      errors++;
      $display("[TB] FAIL mid_wait_setup: resp_ready=%b req_core=%0d core_done=%b required 1/1/01", resp_ready, req_core, core_done);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({core_done, req_valid, resp_ready, req_core, all_done} !== '0 || cycle_count !== '0) begin
      errors++;
      $display("[TB] FAIL mid_wait_reset: core_done=%b req_valid=%b resp_ready=%b req_core=%0d cycle_count=%0d required all 0", core_done, req_valid, resp_ready, req_core, cycle_count);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (req_valid !== 1'b1 || req_core !== 1'b0 || cycle_count !== 64'd1) begin
      errors++;
      $display("[TB] FAIL restart: req_valid=%b req_core=%0d cycle_count=%0d required 1/0/1", req_valid, req_core, cycle_count);
    end
  endtask

  task automatic test_no_stop_on_fail();
    logic [KW-1:0] c;
    reset_dut();
    enable = 1'b1;
    serve(1'b1, 64'd7, c);
    checks++;
    if (n_all_done !== 1'b0 || n_req_valid !== 1'b1 || n_req_core !== 1'b1 || n_core_fail !== 2'b01) begin
      errors++;
      $display("[TB] FAIL nsf_continue: all_done=%b req_valid=%b req_core=%0d core_fail=%b required 0/1/1/01", n_all_done, n_req_valid, n_req_core, n_core_fail);
    end
    serve(1'b1, 64'd1, c);
    checks++;
    if (n_fail_code !== 63'd3 || n_fail_core !== 1'b0 || n_all_done !== 1'b1 || n_any_fail !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nsf_final: fail_code=%0d fail_core=%0d all_done=%b any_fail=%b required 3/0/1/1", n_fail_code, n_fail_core, n_all_done, n_any_fail);
    end
    checks++;
    if (n_core_done !== 2'b11 || n_core_fail !== 2'b01 || n_timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nsf_vectors: core_done=%b core_fail=%b timeout=%b required 11/01/0", n_core_done, n_core_fail, n_timeout);
    end
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_stop_on_fail();
    test_timeout();
    test_backpressure();
    test_reset_mid_wait();
    test_no_stop_on_fail();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
